// File: rtl/cic_row_param.sv
// -----------------------------------------------------------------------------
// cic_row_param
//   A row of NUM_CH independent CIC decimators that share one phase counter.
//   Every enabled channel integrates its 1-bit modulator input on every clock.
//   Once per decimation period (2^D clocks), a strobe runs the comb section.
//   After CIC_ORDER settling strobes, each strobe publishes all channel results
//   into a hold register, guarded by a valid/ready handshake.
//
// Ports
//   clk        modulator clock; the only clock domain
//   reset_n    asynchronous, active-low reset
//   in         per-channel 1-bit sample (weight 0/1)
//   ch_enable  per-channel run enable; a disabled channel is held at zero
//   dec_log2   decimation exponent, sampled only on reset release and on clear
//   clear      synchronous restart; takes priority over publish and transfer
//   out_ready  consumer accepts the held result
//   out        NUM_CH results, channel k in bits [(k+1)*OUT_W-1 : k*OUT_W]
//   out_valid  hold register carries an unread result
//   overrun    sticky: an unread result was overwritten by a newer one
//   frame_cnt  number of published results, modulo 256
// -----------------------------------------------------------------------------
module cic_row_param #(
  parameter int NUM_CH       = 24,
  parameter int CIC_ORDER    = 3,
  parameter int MAX_LOG2_DEC = 8,
  parameter int OUT_W        = CIC_ORDER * MAX_LOG2_DEC + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       in,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [3:0]              dec_log2,
  input  logic                    clear,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] out,
  output logic                    out_valid,
  output logic                    overrun,
  output logic [7:0]              frame_cnt
);

  localparam int PH_W     = MAX_LOG2_DEC;
  localparam int SETTLE_W = 3;  // counts 0..CIC_ORDER, CIC_ORDER <= 4

  // Out-of-range exponents clamp into 1..MAX_LOG2_DEC.
  function automatic logic [3:0] clamp_d(input logic [3:0] v);
    if (v == 4'd0) return 4'd1;
    if (int'(v) > MAX_LOG2_DEC) return 4'(MAX_LOG2_DEC);
    return v;
  endfunction

  // State
  logic                    started_q, started_d;  // D has been latched since reset
  logic [3:0]              d_q, d_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [SETTLE_W-1:0]     settle_q, settle_d;
  logic [OUT_W-1:0]        integ_q     [NUM_CH][CIC_ORDER];
  logic [OUT_W-1:0]        integ_d     [NUM_CH][CIC_ORDER];
  logic [OUT_W-1:0]        comb_prev_q [NUM_CH][CIC_ORDER];
  logic [OUT_W-1:0]        comb_prev_d [NUM_CH][CIC_ORDER];
  logic [NUM_CH*OUT_W-1:0] out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;

  // Decode
  logic [3:0]              d_eff;
  logic [PH_W-1:0]         ph_last;
  logic                    strobe;
  logic                    publish;

  always_comb begin
    logic [OUT_W-1:0] comb_x;

    // NOTE: every signal assigned here receives a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    comb_x = '0;

    // On the first edge after reset release, dec_log2 is used directly and
    // then latched. This lets the phase counter run from that first edge.
    d_eff   = started_q ? d_q : clamp_d(dec_log2);
    ph_last = PH_W'((32'd1 << d_eff) - 32'd1);
    strobe  = (phase_q == ph_last);
    publish = strobe && (settle_q == SETTLE_W'(CIC_ORDER));

    started_d   = 1'b1;
    d_d         = d_eff;
    phase_d     = strobe ? '0 : phase_q + PH_W'(1);
    settle_d    = (strobe && !publish) ? settle_q + SETTLE_W'(1) : settle_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;

    // Handshake. A publish on the transfer edge keeps out_valid high.
    // In that case the old result was consumed, so it is not an overrun.
    if (publish) begin
      out_valid_d = 1'b1;
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    for (int k = 0; k < NUM_CH; k++) begin
      // Integrators. Stage j uses the registered output of stage j-1.
      integ_d[k][0] = integ_q[k][0] + {{(OUT_W-1){1'b0}}, in[k]};
      for (int j = 1; j < CIC_ORDER; j++) begin
        integ_d[k][j] = integ_q[k][j] + integ_q[k][j-1];
      end

      // Combs. Each stage is combinational within the strobe cycle.
      // Only the previous-strobe inputs are stored.
      comb_x = integ_q[k][CIC_ORDER-1];
      for (int j = 0; j < CIC_ORDER; j++) begin
        comb_prev_d[k][j] = strobe ? comb_x : comb_prev_q[k][j];
        comb_x            = comb_x - comb_prev_q[k][j];
      end
      if (publish) out_d[k*OUT_W +: OUT_W] = comb_x;

      // A disabled channel is held at zero state and presents zero.
      if (!ch_enable[k]) begin
        for (int j = 0; j < CIC_ORDER; j++) begin
          integ_d[k][j]     = '0;
          comb_prev_d[k][j] = '0;
        end
        out_d[k*OUT_W +: OUT_W] = '0;
      end
    end

    // Restart: clear overrides everything and re-samples the exponent.
    if (clear) begin
      d_d         = clamp_d(dec_log2);
      phase_d     = '0;
      settle_d    = '0;
      integ_d     = '{default: '0};
      comb_prev_d = '{default: '0};
      out_d       = '0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
      frame_cnt_d = 8'd0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  // This lets every flop sample the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started_q   <= 1'b0;
      d_q         <= '0;
      phase_q     <= '0;
      settle_q    <= '0;
      // NOTE: the integrator and comb arrays are real datapath registers.
      // They are reset here as well as the control flops, so a restart
      // never mixes stale history into the first results.
      integ_q     <= '{default: '0};
      comb_prev_q <= '{default: '0};
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      started_q   <= started_d;
      d_q         <= d_d;
      phase_q     <= phase_d;
      settle_q    <= settle_d;
      integ_q     <= integ_d;
      comb_prev_q <= comb_prev_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule
